// File: rtl/muldiv_pkg.sv
// Shared constants and encodings for the EX-stage iterative multiply/divide unit.
package muldiv_pkg;
  localparam int XLEN  = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;
endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 shift-add multiply / restoring divide on magnitudes, with sign fix-up on the outputs.
module muldiv_datapath
  import muldiv_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs,
  input  logic [XLEN-1:0] i_rt,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);
  logic            w_isdiv, w_signed, w_aneg, w_bneg, w_ge;
  logic [XLEN-1:0] w_aabs, w_babs, w_diff;
  logic [XLEN:0]   w_sum, w_sh;
  logic [2*XLEN-1:0] w_prod;

  logic            r_isdiv, r_qneg, r_rneg, r_div0;
  logic [XLEN-1:0] r_b, r_hi, r_lo;

  assign w_isdiv  = i_op[1];
  assign w_signed = ~i_op[0];
  assign w_aneg   = w_signed & i_rs[XLEN-1];
  assign w_bneg   = w_signed & i_rt[XLEN-1];
  assign w_aabs   = w_aneg ? -i_rs : i_rs;
  assign w_babs   = w_bneg ? -i_rt : i_rt;

  // Multiply: {hi,lo} holds partial product in hi and remaining multiplier bits in lo.
  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  assign w_sh   = {r_hi, r_lo[XLEN-1]};
  assign w_ge   = w_sh >= {1'b0, r_b};
  assign w_diff = w_sh[XLEN-1:0] - r_b;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_isdiv <= 1'b0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_div0  <= 1'b0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (i_load) begin
      r_isdiv <= w_isdiv;
      r_qneg  <= w_aneg ^ w_bneg;
      r_rneg  <= w_aneg;
      r_div0  <= w_isdiv & (i_rt == '0);
      r_b     <= w_isdiv ? w_babs : w_aabs;
      r_hi    <= '0;
      r_lo    <= w_isdiv ? w_aabs : w_babs;
    end else if (i_step) begin
      if (r_isdiv) begin
        r_hi <= w_ge ? w_diff : w_sh[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], w_ge};
      end else begin
        r_hi <= w_sum[XLEN:1];
        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
      end
    end
  end

  assign w_prod = r_qneg ? -{r_hi, r_lo} : {r_hi, r_lo};

  // Divide by zero leaves |dividend| as remainder, so the sign fix restores rs exactly.
  always_comb begin
    o_hi = w_prod[2*XLEN-1:XLEN];
    o_lo = w_prod[XLEN-1:0];
    if (r_isdiv) begin
      o_hi = r_rneg ? -r_hi : r_hi;
      o_lo = r_div0 ? '1 : (r_qneg ? -r_lo : r_lo);
    end
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage MULT/MULTU/DIV/DIVU sequencer: FSM, step counter, HI/LO registers and hazard stall.
module ex_muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs_data_i,
  input  logic [XLEN-1:0] rt_data_i,
  input  logic            use_hilo_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);
  import muldiv_pkg::*;

  state_e           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [XLEN-1:0]  r_hi, r_lo, w_res_hi, w_res_lo;
  logic             w_load, w_step, w_commit;

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      IDLE: if (start_i && !flush_i) begin
        w_load = 1'b1;
        w_next = RUN;
      end
      RUN: if (flush_i) begin
        w_next = IDLE;
      end else begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(ITER-1)) w_next = FIX;
      end
      FIX: begin
        w_commit = !flush_i;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_commit;
      if (w_load)      r_cnt <= '0;
      else if (w_step) r_cnt <= r_cnt + 1'b1;
      if (w_commit) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  muldiv_datapath u_dp (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_op    (op_i),
    .i_rs    (rs_data_i),
    .i_rt    (rt_data_i),
    .o_hi    (w_res_hi),
    .o_lo    (w_res_lo)
  );

  assign busy_o  = (r_state != IDLE);
  assign stall_o = busy_o & (use_hilo_i | start_i);
  assign done_o  = r_done;
  assign hi_o    = r_hi;
  assign lo_o    = r_lo;
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. It consumes the post-forwarding Rs/Rt operands, the same values selected by ForwardA/ForwardB, and computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers over multiple cycles. While an operation is in flight, it raises a stall request to the hazard logic whenever a later instruction touches HI/LO.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
ITER, 32, iteration count per operation; must equal XLEN.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_i  input  1  asynchronous, active-low reset.
start_i  input  1  EX-stage instruction is MULT/MULTU/DIV/DIVU.
op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
rs_data_i  input  XLEN  forwarded operand A (multiplicand / dividend).
rt_data_i  input  XLEN  forwarded operand B (multiplier / divisor).
use_hilo_i  input  1  instruction in ID/EX reads or writes HI/LO (MFHI, MFLO, MTHI, MTLO).
flush_i  input  1  EX-stage flush; aborts any operation.
busy_o  output  1  operation in flight.
stall_o  output  1  stall request to hazard unit.
done_o  output  1  one-cycle pulse: HI/LO just updated.
hi_o  output  XLEN  HI register (high product / remainder).
lo_o  output  XLEN  LO register (low product / quotient).

Behaviour:
- Reset (rst_i=0, async): state IDLE, counter 0, hi_o=0, lo_o=0, busy_o=0, done_o=0. Internal working registers are cleared. Reset mid-operation discards the operation.
- FSM states:
  - IDLE: start_i & ~flush_i sampled at edge T -> RUN; latch op, |operands| for signed ops, and result-sign flags.
  - RUN: one radix-2 step per cycle, counter 0..ITER-1; after step ITER-1 -> FIX.
  - FIX: apply sign correction; write hi_o/lo_o; -> IDLE with done_o=1 the next cycle.
- Latency: busy_o high cycles T+1..T+33 (RUN x32 + FIX). done_o=1 and new hi_o/lo_o visible in cycle T+34; busy_o=0 there.
- Multiply: unsigned shift-add on 64-bit accumulator. For signed ops, negate the product if the operand signs differ.
- Divide: restoring, 1 quotient bit per cycle.
  - Signed: quotient negative iff signs differ; remainder takes dividend's sign.
  - -2^31 / -1: lo=0x80000000, hi=0 (two's-complement wrap; no trap).
- Divide by zero (either signedness): lo=0xFFFFFFFF, hi=rs_data_i as latched. Same 34-cycle latency.
- stall_o = busy_o & (use_hilo_i | start_i). Combinational; deasserts in the done cycle.
- start_i while busy: ignored. The instruction is held by stall_o and re-presented, then accepted in the first IDLE cycle.
- flush_i:
  - In RUN/FIX: -> IDLE next edge; hi_o/lo_o unchanged; no done_o.
  - With start_i in IDLE: flush wins; nothing starts.
- hi_o/lo_o change only in the FIX->IDLE transition; otherwise held.
- MTHI/MTLO writes are not handled here (the HI/LO write port belongs to the WB path). This block only guarantees ordering via stall_o.

Decomposition:
- Package muldiv_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state enum (IDLE, RUN, FIX), XLEN, ITER, counter width.
- One sub-module, muldiv_datapath: accumulator/remainder registers, shift-add/subtract step, sign pre/post-processing.
- ex_muldiv_unit keeps the FSM, counter, handshake and HI/LO registers.

Test Plan:
1. MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> 34 cycles later done_o=1, hi=0xFFFFFFFE, lo=0x00000001; busy_o high exactly 33 cycles.
2. MULT rs=0xFFFFFFFD (-3), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then MULT 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0.
3. DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, done at +34; DIV -5/0 -> lo=0xFFFFFFFF, hi=0xFFFFFFFB.
5. Start MULTU 3*4, hold use_hilo_i=1 from T+1 -> stall_o=1 T+1..T+33, 0 at T+34 with lo=12. A second start_i at T+5 is not accepted until T+34.
6. Load hi/lo=(1,2); start DIVU; flush_i at T+10 -> busy_o=0 at T+11, hi/lo stay (1,2), done_o never pulses. Async rst_i low mid-RUN -> all outputs 0 immediately.
